csd_to_bin: RTL and testbench

//  Inverse of the binary->CSD converter: rebuilds a two's-complement value from an N-digit

---
 rtl/csd_to_bin.sv | 158 +++++++++++++++
 tb/tb_csd_to_bin.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/csd_to_bin.sv
// csd_to_bin: rebuilds a two's-complement value from an N-digit canonical-signed-digit word
// held in a small register file, walking the digits MSB->LSB with a shift-accumulate.
module csd_to_bin #(
  parameter int N  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          we,
  input  logic [AW-1:0] address,
  input  logic [1:0]    digitIn,
  output logic          busy,
  output logic          done,
  output logic [N:0]    result,
  output logic          errCode,
  output logic          errAdj
);

  localparam int            IW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW:0]   NUM_DIGITS = (AW+1)'(N);
  localparam logic [AW-1:0] LAST_IDX   = AW'(N-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_mem [N];
  logic [AW-1:0] r_idx;
  logic [N:0]    r_acc;
  logic [N:0]    r_result;
  logic          r_prev_nz;
  logic          r_busy;
  logic          r_done;
  logic          r_err_code;
  logic          r_err_adj;

  logic [1:0]    w_code;
  logic [N:0]    w_d;
  logic [N:0]    w_acc_nxt;
  logic          w_nz;
  logic          w_illegal;
  logic          w_last;
  logic          w_wr_ok;

  // Digit decode and shift-accumulate step; illegal code 10 contributes zero
  always_comb begin
    w_code    = r_mem[r_idx[IW-1:0]];
    w_d       = '0;
    w_nz      = 1'b0;
    w_illegal = 1'b0;
    case (w_code)
      2'b01: begin
        w_d  = (N+1)'(1);
        w_nz = 1'b1;
      end
      2'b11: begin
        w_d  = '1;
        w_nz = 1'b1;
      end
      2'b10: begin
        w_illegal = 1'b1;
      end
      default: begin
        w_d  = '0;
        w_nz = 1'b0;
      end
    endcase
    w_acc_nxt = {r_acc[N-1:0], 1'b0} + w_d;
    w_last    = (r_idx == '0);
    w_wr_ok   = we && (r_state != S_RUN) && ({1'b0, address} < NUM_DIGITS);
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
        else       w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_state_nxt = S_RUN;
      end
      S_DONE: begin
        if (!start) w_state_nxt = S_IDLE;
        else        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Digit register file, frozen while a conversion runs
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= 2'b00;
    end else if (w_wr_ok) begin
      r_mem[address[IW-1:0]] <= digitIn;
    end
  end

  // Conversion datapath, sticky flags and registered status
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_prev_nz  <= 1'b0;
      r_err_code <= 1'b0;
      r_err_adj  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx      <= LAST_IDX;
            r_acc      <= '0;
            r_prev_nz  <= 1'b0;
            r_err_code <= 1'b0;
            r_err_adj  <= 1'b0;
          end
        end
        S_RUN: begin
          r_acc     <= w_acc_nxt;
          r_prev_nz <= w_nz;
          r_idx     <= r_idx - AW'(1);
          if (w_illegal)           r_err_code <= 1'b1;
          if (w_nz && r_prev_nz)   r_err_adj  <= 1'b1;
          if (w_last)              r_result   <= w_acc_nxt;
        end
        default: begin
          r_idx <= r_idx;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign errCode = r_err_code;
  assign errAdj  = r_err_adj;

endmodule

// File: tb/tb_csd_to_bin.sv
// Self-checking bench for csd_to_bin: a shadow digit file feeds a reference decoder whose
// results go through a scoreboard queue, popped when the DUT raises done.
module tb_csd_to_bin;

  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          we;
  logic [AW-1:0] address;
  logic [1:0]    digitIn;
  logic          busy;
  logic          done;
  logic [N:0]    result;
  logic          errCode;
  logic          errAdj;

  typedef struct packed {
    logic [N:0] res;
    logic       code;
    logic       adj;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] tb_mem [N];
  int         n_cmp = 0;
  int         n_err = 0;

  csd_to_bin #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .address(address),
    .digitIn(digitIn), .busy(busy), .done(done), .result(result),
    .errCode(errCode), .errAdj(errAdj)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic is_nz(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b11);
  endfunction

  function automatic exp_t model_ref();
    int   v;
    exp_t e;
    v = 0;
    e = '0;
    for (int i = 0; i < N; i++) begin
      case (tb_mem[i])
        2'b01:   v = v + (1 << i);
        2'b11:   v = v - (1 << i);
        2'b10:   e.code = 1'b1;
        default: v = v;
      endcase
      if (i < N-1 && is_nz(tb_mem[i]) && is_nz(tb_mem[i+1])) e.adj = 1'b1;
    end
    e.res = v[N:0];
    return e;
  endfunction

  task automatic write_digit(input int a, input logic [1:0] c);
    @(negedge clk);
    we      = 1'b1;
    address = AW'(a);
    digitIn = c;
    @(negedge clk);
    we = 1'b0;
    if (a < N) tb_mem[a] = c;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) write_digit(i, 2'b00);
  endtask

  // wr_at >= 0: attempt a write of +1 to digit 2 at that RUN cycle (must be ignored)
  task automatic run_conv(input string tag, input int wr_at);
    exp_t e;
    int   cyc;
    int   bcnt;
    logic seen;
    sb_q.push_back(model_ref());
    @(negedge clk);
    start = 1'b1;
    cyc   = 0;
    bcnt  = 0;
    seen  = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
      if (cyc == wr_at) begin
        we = 1'b1; address = AW'(2); digitIn = 2'b01;
      end else begin
        we = 1'b0;
      end
    end
    we = 1'b0;
    e  = sb_q.pop_front();
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, cyc, N + 1);
    chk({tag, "_busy_cycles"}, bcnt, N);
    chk({tag, "_result"}, 32'(result), 32'(e.res));
    chk({tag, "_errCode"}, 32'(errCode), 32'(e.code));
    chk({tag, "_errAdj"}, 32'(errAdj), 32'(e.adj));
    @(negedge clk);
    chk({tag, "_done_held"}, 32'(done), 32'd1);
    chk({tag, "_no_restart"}, 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_result_hold"}, 32'(result), 32'(e.res));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    we      = 1'b0;
    address = '0;
    digitIn = 2'b00;
    for (int i = 0; i < N; i++) tb_mem[i] = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({errCode, errAdj}), 32'd0);

    write_digit(0, 2'b01); write_digit(2, 2'b11); write_digit(4, 2'b01);
    run_conv("t1_p13", -1);
    chk("t1_const", 32'(result), 32'h00D);

    clear_mem(); write_digit(7, 2'b11); write_digit(0, 2'b01);
    run_conv("t2_m127", -1);
    chk("t2_const", 32'(result), 32'h181);
    clear_mem();
    write_digit(7, 2'b01); write_digit(5, 2'b01); write_digit(3, 2'b01); write_digit(1, 2'b01);
    run_conv("t2_p170", -1);
    chk("t2b_const", 32'(result), 32'h0AA);

    clear_mem(); write_digit(0, 2'b01); write_digit(1, 2'b01);
    run_conv("t3_adj", -1);
    write_digit(1, 2'b00);
    run_conv("t3_clean", -1);

    clear_mem(); write_digit(3, 2'b10); write_digit(0, 2'b01);
    run_conv("t4_illegal", -1);

    clear_mem();
    write_digit(0, 2'b01); write_digit(2, 2'b11); write_digit(4, 2'b01);
    run_conv("t5_midrun_we", 3);
    write_digit(9, 2'b01);
    run_conv("t5_addr9", -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) write_digit(i, 2'($urandom_range(0, 3)));
      run_conv($sformatf("rnd%0d", r), -1);
    end

    // Reset in the 4th RUN cycle, then a fresh conversion on the cleared file
    clear_mem();
    write_digit(0, 2'b01); write_digit(2, 2'b11); write_digit(4, 2'b01);
    run_conv("t6_pre", -1);
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) tb_mem[i] = 2'b00;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_result", 32'(result), 32'd0);
    chk("t6_flags", 32'({errCode, errAdj}), 32'd0);
    run_conv("t6_fresh", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
